// File: rtl/audio_pkg.sv
// Shared audio types and default sample/slot geometry.
// Exports DEF_RESOLUTION, DEF_SLOT_BITS, I2S_FRAME_BITS, stereo_sample_t.
package audio_pkg;

    localparam int DEF_RESOLUTION = 24;
    localparam int DEF_SLOT_BITS  = 32;
    localparam int I2S_FRAME_BITS = 2 * DEF_SLOT_BITS;

    typedef struct packed {
        logic [DEF_RESOLUTION-1:0] left;
        logic [DEF_RESOLUTION-1:0] right;
    } stereo_sample_t;

endpackage

// File: rtl/i2s_tx_if.sv
// Stereo sample handshake into the I2S serializer.
// master drives left_in/right_in/in_valid; slave drives in_ready.
interface i2s_tx_if #(
    parameter int RESOLUTION = audio_pkg::DEF_RESOLUTION
) ();

    logic [RESOLUTION-1:0] left_in;
    logic [RESOLUTION-1:0] right_in;
    logic                  in_valid;
    logic                  in_ready;

    modport master (
        output left_in,
        output right_in,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  left_in,
        input  right_in,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/i2s_bclk_gen.sv
// Bit clock divider: bclk toggles every BCLK_DIV clk cycles.
// Ports: clk, reset_n, i_enable -> o_bclk, o_bclk_rise, o_bclk_fall.
module i2s_bclk_gen #(
    parameter int BCLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_enable,
    output logic o_bclk,
    output logic o_bclk_rise,
    output logic o_bclk_fall
);

    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DW-1:0] TC = DW'(BCLK_DIV - 1);

    logic [DW-1:0] r_div_cnt;
    logic          r_bclk;
    logic          w_tc;

    assign w_tc = i_enable && (r_div_cnt == TC);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (!i_enable) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (w_tc) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
        end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
        end
    end

    // Strobes mark the clk edge on which the bclk register flips.
    assign o_bclk      = r_bclk;
    assign o_bclk_rise = w_tc && !r_bclk;
    assign o_bclk_fall = w_tc && r_bclk;

endmodule

// File: rtl/i2s_tx.sv
// Stereo I2S transmitter: shadow buffer, frame register, serializer.
// Ports: clk, reset_n, enable, in_if (slave), bclk, lrclk, sdata, underrun.
// Build option I2S_TX_UNDERRUN_MUTE_EN: underrun loads a silent frame
// instead of repeating the previous one.
module i2s_tx
    import audio_pkg::*;
#(
    parameter int RESOLUTION = DEF_RESOLUTION,
    parameter int SLOT_BITS  = DEF_SLOT_BITS,
    parameter int BCLK_DIV   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    i2s_tx_if.slave    in_if,
    output logic       bclk,
    output logic       lrclk,
    output logic       sdata,
    output logic       underrun
);

    localparam int FRAME = 2 * SLOT_BITS;
    localparam int IW    = $clog2(FRAME);
    localparam int SW    = $clog2(SLOT_BITS);
    localparam int R     = RESOLUTION;

    localparam logic [IW-1:0] LAST = IW'(FRAME - 1);
    localparam logic [IW-1:0] SLOT = IW'(SLOT_BITS);

    logic [IW-1:0]        r_bit_idx;
    logic                 r_lrclk;
    logic                 r_sdata;
    logic                 r_underrun;
    logic                 r_shadow_full;
    logic [2*R-1:0]       r_shadow;
    logic [2*R-1:0]       r_frame;

    logic                 w_bclk;
    logic                 w_bclk_fall;
    logic                 w_unused_rise;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_wrap;
    logic [IW-1:0]        w_next_idx;
    logic                 w_next_right;
    logic [SW-1:0]        w_slot_pos;
    logic [R-1:0]         w_chan;
    logic [SLOT_BITS-1:0] w_slot_word;
    logic [SW-1:0]        w_tap;

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_enable    (enable),
        .o_bclk      (w_bclk),
        .o_bclk_rise (w_unused_rise),
        .o_bclk_fall (w_bclk_fall)
    );

    assign w_ready  = enable && !r_shadow_full;
    assign w_accept = in_if.in_valid && w_ready;
    assign in_if.in_ready = w_ready;

    assign w_next_idx = (r_bit_idx == LAST) ? '0
                                            : r_bit_idx + IW'(1);
    assign w_wrap     = w_bclk_fall && (r_bit_idx == LAST);

    assign w_next_right = (w_next_idx >= SLOT);
    assign w_slot_pos   = w_next_right ? SW'(w_next_idx - SLOT)
                                       : SW'(w_next_idx);
    assign w_chan       = w_next_right ? r_frame[R-1:0]
                                       : r_frame[2*R-1:R];

    // Slot image MSB-first: one delay bit, the sample, zero padding.
    // Slot position s reads bit SLOT_BITS-1-s of this word.
    assign w_slot_word = SLOT_BITS'({1'b0, w_chan})
                         << (SLOT_BITS - 1 - R);
    assign w_tap       = SW'(SLOT_BITS - 1) - w_slot_pos;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_idx     <= LAST;
            r_lrclk       <= 1'b0;
            r_sdata       <= 1'b0;
            r_underrun    <= 1'b0;
            r_shadow_full <= 1'b0;
            r_shadow      <= '0;
            r_frame       <= '0;
        end else if (!enable) begin
            r_bit_idx     <= LAST;
            r_lrclk       <= 1'b0;
            r_sdata       <= 1'b0;
            r_underrun    <= 1'b0;
            r_shadow_full <= 1'b0;
            r_shadow      <= '0;
            r_frame       <= '0;
        end else begin
            r_underrun <= 1'b0;
            if (w_bclk_fall) begin
                r_bit_idx <= w_next_idx;
                r_lrclk   <= w_next_right;
                r_sdata   <= w_slot_word[w_tap];
            end
            if (w_wrap) begin
                if (r_shadow_full) begin
                    r_frame <= r_shadow;
                end else begin
                    r_underrun <= 1'b1;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
                    r_frame <= '0;
`else
                    r_frame <= r_frame;
`endif
                end
            end
            // A sample arriving on the wrap edge never bypasses into
            // the frame; it waits in the shadow for the next one.
            if (w_accept) begin
                r_shadow      <= {in_if.left_in, in_if.right_in};
                r_shadow_full <= 1'b1;
            end else if (w_wrap && r_shadow_full) begin
                r_shadow_full <= 1'b0;
            end
        end
    end

    assign bclk     = w_bclk;
    assign lrclk    = r_lrclk;
    assign sdata    = r_sdata;
    assign underrun = r_underrun;

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Stereo I2S serializer at the output of the effects chain; sends processed samples to the codec DAC.
- Takes parallel left/right samples through a valid/ready handshake and holds them in a one-entry shadow buffer.
- Generates BCLK, LRCLK and SDATA from the single system clock.

Parameters:
- RESOLUTION, 24, sample width in bits (two's complement); must be <= SLOT_BITS-1.
- SLOT_BITS, 32, BCLK periods per channel slot; the frame is 2*SLOT_BITS.
- BCLK_DIV, 4, clk cycles per BCLK half-period (>=1).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  serializer enable.
- left_in  input  RESOLUTION  left sample.
- right_in  input  RESOLUTION  right sample.
- in_valid  input  1  left_in/right_in valid.
- in_ready  output  1  shadow buffer empty and enable high.
- bclk  output  1  serial bit clock.
- lrclk  output  1  word select (0 = left, 1 = right).
- sdata  output  1  serial data, MSB first.
- underrun  output  1  one-clk pulse when a frame starts with no new sample.

Behaviour:
- Clock/reset: one clock, clk; reset_n is asynchronous, active-low.
- Reset values: bclk=0, lrclk=0, sdata=0, underrun=0, div_cnt=0, bit_idx=2*SLOT_BITS-1, shadow empty, frame register=0.
- in_ready = enable && !shadow_full (combinational from registers).
- Handshake: accepted when in_valid && in_ready at a clk edge; the shadow latches {left_in,right_in} and shadow_full sets.
- Divider: div_cnt counts 0..BCLK_DIV-1. At terminal count it wraps and bclk toggles. BCLK period = 2*BCLK_DIV clk.
- On each bclk falling toggle (1->0):
  - bit_idx advances modulo 2*SLOT_BITS.
  - lrclk, sdata and the frame load update in the same clk edge.
- lrclk = (new bit_idx >= SLOT_BITS).
- Slot position s = bit_idx mod SLOT_BITS:
  - s=0: sdata=0 (one-bit I2S delay).
  - 1<=s<=RESOLUTION: sdata = channel bit RESOLUTION-s.
  - s>RESOLUTION: sdata=0.
- Frame load when bit_idx wraps to 0:
  - Shadow full: frame register <= shadow, shadow_full clears.
  - Shadow empty: underrun=1 for that clk, and frame register follows the optional-feature rule.
- Simultaneous accept and frame load, shadow full: the frame takes the old shadow contents; the shadow takes the new input and stays full.
- Simultaneous accept and frame load, shadow empty: underrun still fires (no bypass), and the new sample lands in the shadow for the next frame.
- Latency: an accepted sample starts transmitting at the next frame boundary; its MSB appears one BCLK after the lrclk falling edge.
- enable low:
  - Synchronously returns all state to the reset values and clears the shadow.
  - in_ready=0; no underrun pulses.
  - On re-enable, behaviour is identical to release from reset.
- Reset asserted mid-frame: outputs go to reset values immediately; any pending shadow sample is lost.

Optional Feature:
- Macro: I2S_TX_UNDERRUN_MUTE_EN.
- Defined: on underrun the frame register loads zero (both channels mute).
- Undefined: on underrun the frame register keeps the previous frame (last sample repeats).
- underrun pulses in both builds.

Decomposition:
- Shared package audio_pkg:
  - RESOLUTION and SLOT_BITS defaults.
  - stereo_sample_t struct {left, right}.
  - I2S_FRAME_BITS constant.
- One sub-module, i2s_bclk_gen:
  - Holds the divider and bclk register.
  - Outputs bclk, bclk_rise and bclk_fall single-cycle strobes.
- i2s_tx keeps the bit index, shadow/frame registers and handshake.

Test Plan:
All tests use BCLK_DIV=2, SLOT_BITS=32, RESOLUTION=24 (BCLK = 4 clk, frame = 256 clk).
1. Reset: assert reset_n=0 mid-frame with shadow full -> bclk/lrclk/sdata/underrun=0 immediately; after release with enable=1, in_ready=1 and the shadow is empty.
2. Single sample: L=24'h800001, R=24'h7FFFFE before the first frame -> sampled on bclk rising edges:
   - lrclk=0: left slot bits 1..24 = 1000_0000_0000_0000_0000_0001, bit 0 and bits 25..31 zero.
   - lrclk=1: right slot = 0111_1111_1111_1111_1111_1110.
3. Underrun: no sample after test 2 -> underrun pulses exactly once per 256 clk. Without the macro the frame repeats 800001/7FFFFE; with I2S_TX_UNDERRUN_MUTE_EN, sdata stays 0.
4. Streaming: in_valid held high with L=R=n, n incrementing per accept -> in_ready drops after each accept and rises at each frame load; consecutive frames carry n, n+1, n+2; no underrun.
5. Collision: assert in_valid in exactly the clk of frame load:
   - Shadow empty: underrun=1, sample A transmits in the following frame.
   - Shadow holding B: B transmits now, A next.
6. Enable drop: deassert enable mid-right-slot for 10 clk, then reassert -> outputs 0 and in_ready=0 while low; the first frame after re-enable starts with lrclk=0 and underrun fires unless a sample was accepted first.
